// File: rtl/cdc_handshake_rx.sv
// Receive side of a four-phase req/ack CDC handshake: synchronizes req_in, captures data_in,
// presents it on a valid/ready port and returns ack_out. Optional checker: CDC_RX_PROTOCOL_CHECK_EN.
module cdc_handshake_rx #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             ack_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_req_sync_chain;
  logic                   r_ack;
  logic                   r_out_valid;
  logic [WIDTH-1:0]       r_out_data;
  logic                   w_req_sync;

  // Dedicated synchronizer chain: the only reader of req_in, kept free of other logic so the
  // CDC tool recognizes it.
  // NOTE: sequential state always uses non-blocking assignments so every flop samples the
  // pre-edge value of its neighbour; blocking here would collapse the chain into one flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_req_sync_chain <= '0;
    end else begin
      r_req_sync_chain <= {r_req_sync_chain[SYNC_STAGES-2:0], req_in};
    end
  end

  assign w_req_sync = r_req_sync_chain[SYNC_STAGES-1];

  // NOTE: the captured data register is reset along with control; unlike a RAM it is a plain
  // register bank, and a defined value on out_data after reset is part of the contract.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_ack       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_req_sync) begin
            r_out_data  <= data_in;
            r_out_valid <= 1'b1;
            r_state     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          // A premature req drop is tolerated here: the captured word is still delivered.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_ack       <= 1'b1;
            r_state     <= ST_ACK;
          end
        end
        ST_ACK: begin
          if (!w_req_sync) begin
            r_ack   <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_ack       <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign ack_out   = r_ack;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = (r_state != ST_IDLE);

`ifdef CDC_RX_PROTOCOL_CHECK_EN
  logic r_err;

  // Sticky: data must stay stable while req is held, and req must not drop before ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if (r_state == ST_HOLD) begin
      if (!w_req_sync || (data_in != r_out_data)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_handshake_rx.sv
// Scoreboard bench for cdc_handshake_rx: stimulus pushes expected words, a negedge monitor
// pops and compares every accepted word; directed timing checks run inline.
module tb_cdc_handshake_rx;

  localparam int WIDTH       = 8;
  localparam int SYNC_STAGES = 2;
  localparam int WAIT_LIMIT  = 50;

`ifdef CDC_RX_PROTOCOL_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic             req_in;
  logic [WIDTH-1:0] data_in;
  logic             ack_out;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;
  logic             err;

  int n_checks   = 0;
  int n_errors   = 0;
  int n_pushed   = 0;
  int n_accepted = 0;
  logic [WIDTH-1:0] exp_q[$];

  cdc_handshake_rx #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_in   (req_in),
    .data_in  (data_in),
    .ack_out  (ack_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [WIDTH-1:0] d);
    exp_q.push_back(d);
    n_pushed++;
  endtask

  task automatic wait_ack(input logic level, input string name);
    for (int i = 0; i < WAIT_LIMIT; i++) begin
      if (ack_out == level) break;
      tick(1);
    end
    check(name, ack_out, level);
  endtask

  // Compliant transmitter: raise req, wait ack, drop req, wait ack low.
  task automatic send_word(input logic [WIDTH-1:0] d);
    data_in = d;
    push_word(d);
    req_in = 1'b1;
    wait_ack(1'b1, "b2b_ack_high");
    req_in = 1'b0;
    wait_ack(1'b0, "b2b_ack_low");
    tick(1);
  endtask

  // Monitor: an accept happens at the next posedge when valid and ready are both high here.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      check("sb_word_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        check("sb_out_data", out_data, exp_q.pop_front());
      end
      n_accepted++;
    end
  end

  initial begin
    reset     = 1'b0;
    req_in    = 1'b1;
    data_in   = 8'h77;
    out_ready = 1'b0;

    // Reset with req already high: everything zero, then capture 3 cycles after release.
    tick(3);
    check("rst_ack",       ack_out,   0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy",      busy,      0);
    check("rst_err",       err,       0);
    check("rst_out_data",  out_data,  0);
    reset = 1'b1;
    push_word(8'h77);
    tick(2);
    check("rst_valid_early", out_valid, 0);
    tick(1);
    check("rst_valid_rise", out_valid, 1);
    check("rst_data",       out_data,  8'h77);
    out_ready = 1'b1;
    wait_ack(1'b1, "rst_ack_high");
    req_in = 1'b0;
    wait_ack(1'b0, "rst_ack_low");
    tick(1);

    // Single transfer with out_ready high.
    data_in = 8'hA5;
    push_word(8'hA5);
    req_in = 1'b1;
    tick(2);
    check("single_valid_early", out_valid, 0);
    tick(1);
    check("single_valid", out_valid, 1);
    check("single_data",  out_data,  8'hA5);
    check("single_busy",  busy,      1);
    check("single_ack0",  ack_out,   0);
    tick(1);
    check("single_valid_pulse", out_valid, 0);
    check("single_ack1",        ack_out,   1);
    req_in = 1'b0;
    tick(2);
    check("single_ack_hold", ack_out, 1);
    tick(1);
    check("single_ack_fall", ack_out, 0);
    check("single_busy_end", busy,    0);
    tick(1);

    // Backpressure: word and valid stable, no ack while out_ready is low.
    out_ready = 1'b0;
    data_in = 8'h3C;
    push_word(8'h3C);
    req_in = 1'b1;
    tick(3);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", out_valid, 1);
      check("bp_data",  out_data,  8'h3C);
      check("bp_ack",   ack_out,   0);
      tick(1);
    end
    out_ready = 1'b1;
    tick(1);
    check("bp_ack_rise",   ack_out,   1);
    check("bp_valid_fall", out_valid, 0);
    req_in = 1'b0;
    wait_ack(1'b0, "bp_ack_low");
    tick(1);

    // Back-to-back words.
    send_word(8'h01);
    send_word(8'h02);
    send_word(8'h03);
    check("b2b_accepted", n_accepted, 6);

    // Reset while in ACK: ack drops without a clock edge.
    data_in = 8'h99;
    push_word(8'h99);
    req_in = 1'b1;
    wait_ack(1'b1, "rack_ack_high");
    reset = 1'b0;
    #1;
    check("rack_ack_async",  ack_out,   0);
    check("rack_busy_async", busy,      0);
    check("rack_valid",      out_valid, 0);
    req_in = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(4);
    check("rack_idle",  busy,      0);
    check("rack_noval", out_valid, 0);

    // Data changes during HOLD: err only with the checker built, sticky until reset.
    out_ready = 1'b0;
    data_in = 8'h55;
    push_word(8'h55);
    req_in = 1'b1;
    tick(3);
    check("err_valid", out_valid, 1);
    check("err_before", err, 0);
    data_in = 8'h56;
    tick(2);
    check("err_set", err, ERR_EXP);
    out_ready = 1'b1;
    wait_ack(1'b1, "err_ack_high");
    req_in = 1'b0;
    wait_ack(1'b0, "err_ack_low");
    tick(3);
    check("err_sticky", err, ERR_EXP);
    reset = 1'b0;
    #1;
    check("err_cleared", err, 0);
    reset = 1'b1;
    tick(2);

    check("sb_all_accepted", n_accepted, n_pushed);
    check("sb_queue_empty",  exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
